// File: rtl/dat_mem_stack.sv
// Single-port data memory whose top STK_DEPTH words double as a downward-growing hardware stack.
// Define DAT_MEM_STK_GUARD_EN to block random-access writes into the live stack region.
module dat_mem_stack #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int STK_DEPTH = 16,
    localparam int CW       = $clog2(STK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    output logic [DW-1:0] dat_out,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] stk_in,
    input  logic          err_clr,
    output logic [DW-1:0] stk_top,
    output logic [CW-1:0] stk_cnt,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          stk_err,
    output logic          guard_err
);

    logic [DW-1:0] core_q [2**AW];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stk_err_q, stk_err_d;
    logic [AW-1:0] top_addr, push_addr, stk_waddr;
    logic          stk_we, rand_we, err_set, full, empty;

    // Modular arithmetic gives 2**AW - cnt without an extra address bit.
    assign top_addr  = AW'(0) - AW'(cnt_q);
    assign push_addr = top_addr - AW'(1);
    assign full      = (cnt_q == CW'(STK_DEPTH));
    assign empty     = (cnt_q == '0);

    always_comb begin
        cnt_d     = cnt_q;
        stk_we    = 1'b0;
        stk_waddr = push_addr;
        err_set   = 1'b0;
        case ({push, pop})
            2'b11: begin
                stk_we = 1'b1;
                if (empty) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    stk_waddr = top_addr;
                end
            end
            2'b10: begin
                if (full) begin
                    err_set = 1'b1;
                end else begin
                    stk_we = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
        stk_err_d = err_set | (stk_err_q & ~err_clr);
    end

`ifdef DAT_MEM_STK_GUARD_EN
    logic guard_hit, guard_err_q, guard_err_d;

    // The live region runs from the current top up to the last address.
    always_comb begin
        guard_hit   = wr_en && !empty && (addr >= top_addr);
        guard_err_d = guard_hit | (guard_err_q & ~err_clr);
        rand_we     = wr_en && !guard_hit && !(stk_we && (addr == stk_waddr));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard_err_q <= 1'b0;
        end else begin
            guard_err_q <= guard_err_d;
        end
    end

    assign guard_err = guard_err_q;
`else
    assign rand_we   = wr_en && !(stk_we && (addr == stk_waddr));
    assign guard_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            stk_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stk_err_q <= stk_err_d;
        end
    end

    // Array is never cleared; requests are simply dropped while reset is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (stk_we) begin
                core_q[stk_waddr] <= stk_in;
            end
            if (rand_we) begin
                core_q[addr] <= dat_in;
            end
        end
    end

    assign dat_out   = core_q[addr];
    assign stk_top   = empty ? '0 : core_q[top_addr];
    assign stk_cnt   = cnt_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = stk_err_q;

endmodule

// File: tb/tb_dat_mem_stack.sv
// Self-checking bench for dat_mem_stack: directed scenarios followed by a random phase,
// all compared against an array/counter reference model of the stack rules.
module tb_dat_mem_stack;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NW    = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_in;
    logic [DW-1:0] dat_out;
    logic          push;
    logic          pop;
    logic [DW-1:0] stk_in;
    logic          err_clr;
    logic [DW-1:0] stk_top;
    logic [CW-1:0] stk_cnt;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;
    logic          guard_err;

    dat_mem_stack #(.DW(DW), .AW(AW), .STK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .addr      (addr),
        .dat_in    (dat_in),
        .dat_out   (dat_out),
        .push      (push),
        .pop       (pop),
        .stk_in    (stk_in),
        .err_clr   (err_clr),
        .stk_top   (stk_top),
        .stk_cnt   (stk_cnt),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err),
        .guard_err (guard_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array, occupancy count and two sticky flags.
    logic [DW-1:0] m_mem [NW];
    int            m_cnt;
    bit            m_err;
    bit            m_gerr;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        logic [DW-1:0] exp_top;
        exp_top = (m_cnt > 0) ? m_mem[NW - m_cnt] : '0;
        check_value({tag, "/cnt"},   32'(stk_cnt),   32'(m_cnt));
        check_value({tag, "/full"},  32'(stk_full),  32'(m_cnt == DEPTH));
        check_value({tag, "/empty"}, 32'(stk_empty), 32'(m_cnt == 0));
        check_value({tag, "/err"},   32'(stk_err),   32'(m_err));
        check_value({tag, "/gerr"},  32'(guard_err), 32'(m_gerr));
        check_value({tag, "/top"},   32'(stk_top),   32'(exp_top));
    endtask

    task automatic check_dat(input string tag, input int a);
        addr = AW'(a);
        #1;
        check_value({tag, "/dat"}, 32'(dat_out), 32'(m_mem[a]));
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_err  = 1'b0;
        m_gerr = 1'b0;
    endtask

    // Applies the stack/array rules to the inputs present at this clock edge.
    task automatic model_step();
        int old;
        int swr;
        bit es;
        bit gs;
        bit rw;
        old = m_cnt;
        swr = -1;
        es  = 1'b0;
        gs  = 1'b0;
        if (reset) return;
        if (push && pop) begin
            if (old > 0) begin
                swr = NW - old;
            end else begin
                swr   = NW - 1;
                m_cnt = 1;
            end
        end else if (push) begin
            if (old == DEPTH) es = 1'b1;
            else begin
                swr   = NW - 1 - old;
                m_cnt = old + 1;
            end
        end else if (pop) begin
            if (old == 0) es = 1'b1;
            else m_cnt = old - 1;
        end
        rw = wr_en;
`ifdef DAT_MEM_STK_GUARD_EN
        if (wr_en && old > 0 && int'(addr) >= NW - old) begin
            rw = 1'b0;
            gs = 1'b1;
        end
`endif
        if (rw && int'(addr) != swr) m_mem[addr] = dat_in;
        if (swr >= 0) m_mem[swr] = stk_in;
        m_err  = es ? 1'b1 : (err_clr ? 1'b0 : m_err);
        m_gerr = gs ? 1'b1 : (err_clr ? 1'b0 : m_gerr);
    endtask

    // Drives one cycle of inputs just after an edge, then advances through the next edge.
    task automatic apply_stimulus(input bit p, input bit q, input bit w, input int a,
                                  input int d, input int s, input bit c);
        push    = p;
        pop     = q;
        wr_en   = w;
        addr    = AW'(a);
        dat_in  = DW'(d);
        stk_in  = DW'(s);
        err_clr = c;
        @(posedge clk);
        model_step();
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        wr_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        wr_en   = 1'b0;
        err_clr = 1'b0;
        addr    = '0;
        dat_in  = '0;
        stk_in  = '0;
        for (int i = 0; i < NW; i++) m_mem[i] = 'x;
        model_reset();
        #12;
        check_flags("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Give every word a known value so later reads have defined expectations.
        for (int i = 0; i < NW; i++) apply_stimulus(0, 0, 1, i, (i * 7 + 1) & 8'hFF, 0, 0);

        apply_stimulus(0, 0, 1, 3, 8'hA5, 0, 0);
        check_dat("wr3", 3);
        check_value("wr3_const", 32'(dat_out), 32'h0000_00A5);
        check_dat("rd4", 4);

        apply_stimulus(1, 0, 0, 0, 0, 8'h11, 0);
        apply_stimulus(1, 0, 0, 0, 0, 8'h22, 0);
        check_flags("push2");
        check_value("push2_top", 32'(stk_top), 32'h22);
        check_dat("push2_255", 255);
        check_dat("push2_254", 254);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0);
        check_flags("pop1");
        check_value("pop1_top", 32'(stk_top), 32'h11);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0);
        check_flags("pop_to_empty");

        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 0, 0, 0, 0, 8'h80 + i, 0);
        check_flags("fill");
        check_value("fill_full", 32'(stk_full), 32'h1);
        apply_stimulus(1, 0, 0, 0, 0, 8'hEE, 0);
        check_flags("overflow");
        check_dat("overflow_239", 239);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_flags("errclr_ovf");

        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 1, 0, 0, 0, 0, 0);
        check_flags("drain");
        apply_stimulus(0, 1, 0, 0, 0, 0, 0);
        check_flags("underflow");
        apply_stimulus(0, 1, 0, 0, 0, 0, 1);
        check_flags("clr_vs_new_err");
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_flags("errclr_unf");

        apply_stimulus(1, 1, 0, 0, 0, 8'h33, 0);
        check_flags("pushpop_empty");
        apply_stimulus(1, 0, 0, 0, 0, 8'h44, 0);
        apply_stimulus(1, 0, 0, 0, 0, 8'h55, 0);
        apply_stimulus(1, 1, 0, 0, 0, 8'h5A, 0);
        check_flags("pushpop_3");
        check_value("pushpop_3_top", 32'(stk_top), 32'h5A);

        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 1, 255, 8'h99, 8'h61, 0);
        check_dat("collide_255", 255);
        apply_stimulus(1, 0, 1, 10, 8'h77, 8'h62, 0);
        check_dat("both_10", 10);
        check_dat("both_254", 254);
        check_flags("both");

        apply_stimulus(0, 0, 1, 255, 8'hFF, 0, 0);
        check_flags("guard");
        check_dat("guard_255", 255);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_flags("guard_clr");

        // Reset asserted between edges partway through a push burst.
        apply_stimulus(1, 0, 0, 0, 0, 8'hC1, 0);
        apply_stimulus(1, 0, 0, 0, 0, 8'hC2, 0);
        apply_stimulus(1, 0, 0, 0, 0, 8'hEE, 0);
        push   = 1'b1;
        stk_in = 8'hD0;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_flags("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_flags("rst_hold");
        end
        push  = 1'b0;
        reset = 1'b0;
        check_dat("rst_mem_252", 252);
        apply_stimulus(1, 0, 0, 0, 0, 8'hD1, 0);
        check_flags("post_rst");

        for (int n = 0; n < 400; n++) begin
            int a;
            a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(232, 255)) : int'($urandom_range(0, 255));
            apply_stimulus($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                           a, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           $urandom_range(0, 9) == 0);
            check_flags("rand");
            check_dat("rand", a);
            check_dat("rand_any", int'($urandom_range(0, 255)));
        end

        $display("[TB] directed and random phases complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dat_mem_stack.md
DAT_MEM_STACK -- requirements
Module: dat_mem_stack

Interface
REQ-001 Parameter DW, default 8: data word width in bits.
REQ-002 Parameter AW, default 8: address width; array depth is 2**AW words.
REQ-003 Parameter STK_DEPTH, default 16: stack capacity in words, located at addresses 2**AW-STK_DEPTH .. 2**AW-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  random-access write enable.
REQ-007 addr  input  AW  random-access address.
REQ-008 dat_in  input  DW  random-access write data.
REQ-009 dat_out  output  DW  random-access read data.
REQ-010 push  input  1  stack push request.
REQ-011 pop  input  1  stack pop request.
REQ-012 stk_in  input  DW  push data.
REQ-013 err_clr  input  1  clears sticky error flags.
REQ-014 stk_top  output  DW  word at current top of stack; 0 when empty.
REQ-015 stk_cnt  output  $clog2(STK_DEPTH+1)  current stack occupancy.
REQ-016 stk_full  output  1  high when stk_cnt == STK_DEPTH.
REQ-017 stk_empty  output  1  high when stk_cnt == 0.
REQ-018 stk_err  output  1  sticky overflow/underflow flag.
REQ-019 guard_err  output  1  sticky flag for a blocked write into the live stack region.

Function
REQ-020 dat_out shall equal core[addr] combinationally, with no clock or enable.
REQ-021 When wr_en=1, core[addr] shall be written with dat_in at the next rising edge.
REQ-022 The stack shall grow downward: the first push goes to 2**AW-1, and the top address is 2**AW-stk_cnt.
REQ-023 stk_top shall be combinational: core[2**AW-stk_cnt] when stk_cnt>0, else 0.
REQ-024 A push without pop, when not full, shall write stk_in to 2**AW-1-stk_cnt and increment stk_cnt, visible next cycle.
REQ-025 A push without pop, when full, shall write nothing, leave stk_cnt unchanged and set stk_err.
REQ-026 A pop without push, when not empty, shall decrement stk_cnt; memory contents are unchanged.
REQ-027 A pop without push, when empty, shall leave stk_cnt at 0 and set stk_err.
REQ-028 push and pop together with stk_cnt>0 shall overwrite the top word with stk_in, stk_cnt unchanged, no error.
REQ-029 push and pop together with stk_cnt==0 shall behave as a push only, no error.
REQ-030 If wr_en and a stack write target the same address in one cycle, the stack write shall win and the random write is dropped; different addresses shall both be written.
REQ-031 err_clr shall clear stk_err and guard_err at the next edge; a new error in the same cycle shall take precedence (the flag stays 1).
REQ-032 stk_cnt shall never exceed STK_DEPTH or wrap below 0.

Reset
REQ-033 Asserting reset shall immediately force stk_cnt=0, stk_empty=1, stk_full=0, stk_err=0, guard_err=0 and stk_top=0, independent of clk.
REQ-034 Array contents shall not be reset; dat_out continues to reflect core[addr].
REQ-035 Push, pop and write requests shall be ignored while reset is high, including a reset asserted mid-burst.

Configuration
REQ-036 Macro DAT_MEM_STK_GUARD_EN defined: wr_en to an address in 2**AW-stk_cnt .. 2**AW-1 while stk_cnt>0 shall be suppressed and shall set guard_err.
REQ-037 Macro DAT_MEM_STK_GUARD_EN undefined: such writes shall proceed normally, and guard_err shall be tied to 0.

Verification (defaults DW=8, AW=8, STK_DEPTH=16; stack region 240..255)
REQ-038 Write 0xA5 to addr 3 -> after the edge, dat_out=0xA5 with addr=3, same cycle as addr is applied.
REQ-039 Push 0x11, then 0x22 -> stk_cnt=2, core[255]=0x11, core[254]=0x22, stk_top=0x22; pop -> stk_cnt=1, stk_top=0x11.
REQ-040 16 pushes -> stk_full=1; 17th push -> stk_cnt=16, stk_err=1, core[239] unchanged; err_clr -> stk_err=0.
REQ-041 Pop when empty -> stk_cnt=0, stk_err=1; push+pop at stk_cnt=3 with stk_in=0x5A -> stk_cnt=3, stk_top=0x5A, stk_err unchanged.
REQ-042 stk_cnt=2, wr_en to addr 255 with 0xFF -> with macro: core[255] unchanged, guard_err=1; without macro: core[255]=0xFF, guard_err=0.
REQ-043 Assert reset between clock edges during a push burst -> stk_cnt=0 and stk_empty=1 immediately; pushes are ignored until reset deasserts.
